mem_stage_core: RTL and testbench

//  Memory-access (MEM) stage of the 5-stage pipelined ARM-style core; sits between EX and WB.

---
 rtl/mem_stage_core.sv | 84 ++++++++
 tb/tb_mem_stage_core.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_core.sv
// MEM stage: word-addressed data memory plus the MEM/WB pipeline register.
// Loads read the word as it was before a same-edge store to that word.
module mem_stage_core #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int ADDR_BITS  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_Pc,
    input  logic                  i_Sig_Write_Back_Enable,
    input  logic                  i_Sig_Memory_Read_Enable,
    input  logic                  i_Sig_Memory_Write_Enable,
    input  logic [DATA_WIDTH-1:0] i_ALU_Result,
    input  logic [DATA_WIDTH-1:0] i_Value_Rm,
    input  logic [3:0]            i_Destination,
    output logic [DATA_WIDTH-1:0] o_Pc,
    output logic                  o_Sig_Write_Back_Enable,
    output logic                  o_Sig_Memory_Read_Enable,
    output logic [DATA_WIDTH-1:0] o_Memory_Result,
    output logic [3:0]            o_Destination,
    output logic [DATA_WIDTH-1:0] o_Data_Memory
);

    logic [ADDR_BITS-1:0]  idx;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  wb_q, wb_d;
    logic                  rd_q, rd_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [3:0]            dst_q, dst_d;
    logic [DATA_WIDTH-1:0] dm_q, dm_d;

    // Byte offset and bits above the memory size are dropped, so addresses wrap.
    assign idx = i_ALU_Result[ADDR_BITS+1:2];

    always_comb begin
        mem_d = mem_q;
        if (i_Sig_Memory_Write_Enable) begin
            mem_d[idx] = i_Value_Rm;
        end
    end

    always_comb begin
        pc_d  = i_Pc;
        wb_d  = i_Sig_Write_Back_Enable;
        rd_d  = i_Sig_Memory_Read_Enable;
        res_d = i_ALU_Result;
        dst_d = i_Destination;
        dm_d  = i_Sig_Memory_Read_Enable ? mem_q[idx] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pc_q  <= '0;
            wb_q  <= 1'b0;
            rd_q  <= 1'b0;
            res_q <= '0;
            dst_q <= '0;
            dm_q  <= '0;
        end else begin
            mem_q <= mem_d;
            pc_q  <= pc_d;
            wb_q  <= wb_d;
            rd_q  <= rd_d;
            res_q <= res_d;
            dst_q <= dst_d;
            dm_q  <= dm_d;
        end
    end

    assign o_Pc                     = pc_q;
    assign o_Sig_Write_Back_Enable  = wb_q;
    assign o_Sig_Memory_Read_Enable = rd_q;
    assign o_Memory_Result          = res_q;
    assign o_Destination            = dst_q;
    assign o_Data_Memory            = dm_q;

endmodule

// File: tb/tb_mem_stage_core.sv
// Bench for mem_stage_core: directed scenarios plus random traffic
// against an array-based memory model.
module tb_mem_stage_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_Pc;
    logic        i_Sig_Write_Back_Enable;
    logic        i_Sig_Memory_Read_Enable;
    logic        i_Sig_Memory_Write_Enable;
    logic [31:0] i_ALU_Result;
    logic [31:0] i_Value_Rm;
    logic [3:0]  i_Destination;
    logic [31:0] o_Pc;
    logic        o_Sig_Write_Back_Enable;
    logic        o_Sig_Memory_Read_Enable;
    logic [31:0] o_Memory_Result;
    logic [3:0]  o_Destination;
    logic [31:0] o_Data_Memory;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] ref_mem [64];
    logic [31:0] e_pc, e_res, e_dm;
    logic        e_wb, e_rd;
    logic [3:0]  e_dst;

    always #5 clk = ~clk;

    mem_stage_core dut (
        .clk                       (clk),
        .reset                     (reset),
        .i_Pc                      (i_Pc),
        .i_Sig_Write_Back_Enable   (i_Sig_Write_Back_Enable),
        .i_Sig_Memory_Read_Enable  (i_Sig_Memory_Read_Enable),
        .i_Sig_Memory_Write_Enable (i_Sig_Memory_Write_Enable),
        .i_ALU_Result              (i_ALU_Result),
        .i_Value_Rm                (i_Value_Rm),
        .i_Destination             (i_Destination),
        .o_Pc                      (o_Pc),
        .o_Sig_Write_Back_Enable   (o_Sig_Write_Back_Enable),
        .o_Sig_Memory_Read_Enable  (o_Sig_Memory_Read_Enable),
        .o_Memory_Result           (o_Memory_Result),
        .o_Destination             (o_Destination),
        .o_Data_Memory             (o_Data_Memory)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},  o_Pc, e_pc);
        chk({tag, ".wb"},  {31'b0, o_Sig_Write_Back_Enable}, {31'b0, e_wb});
        chk({tag, ".rd"},  {31'b0, o_Sig_Memory_Read_Enable}, {31'b0, e_rd});
        chk({tag, ".res"}, o_Memory_Result, e_res);
        chk({tag, ".dst"}, {28'b0, o_Destination}, {28'b0, e_dst});
        chk({tag, ".dm"},  o_Data_Memory, e_dm);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        e_pc = 0; e_wb = 0; e_rd = 0; e_res = 0; e_dst = 0; e_dm = 0;
    endtask

    // Drive one instruction (called just after a falling edge), clock it,
    // predict with the model, and check at the next falling edge.
    task automatic step(input string tag, input logic [31:0] pc,
                        input logic wb, input logic rd, input logic wr,
                        input logic [31:0] alu, input logic [31:0] rm,
                        input logic [3:0] dst);
        int w;
        i_Pc = pc;
        i_Sig_Write_Back_Enable = wb;
        i_Sig_Memory_Read_Enable = rd;
        i_Sig_Memory_Write_Enable = wr;
        i_ALU_Result = alu;
        i_Value_Rm = rm;
        i_Destination = dst;
        @(posedge clk);
        w = (alu / 4) % 64;
        e_pc = pc; e_wb = wb; e_rd = rd; e_res = alu; e_dst = dst;
        e_dm = rd ? ref_mem[w] : 32'h0;
        if (wr) ref_mem[w] = rm;
        @(negedge clk);
        chk_all(tag);
    endtask

    task automatic load(input string tag, input logic [31:0] alu);
        step(tag, 32'h0, 1'b1, 1'b1, 1'b0, alu, 32'h0, 4'h0);
    endtask

    task automatic rand_inputs();
        i_Pc = $urandom;
        i_Sig_Write_Back_Enable = 1'($urandom);
        i_Sig_Memory_Read_Enable = 1'($urandom);
        i_Sig_Memory_Write_Enable = 1'($urandom);
        i_ALU_Result = $urandom;
        i_Value_Rm = $urandom;
        i_Destination = 4'($urandom);
    endtask

    initial begin
        reset = 1'b0;
        rand_inputs();
        clear_model();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            rand_inputs();
        end
        @(negedge clk);
        chk_all("reset");
        reset = 1'b1;

        for (int i = 0; i < 4; i++) load("rst_load", $urandom);

        step("store", 32'h1000, 1'b1, 1'b0, 1'b1, 32'h2000, 32'hABCD1234, 4'h1);
        step("ld_st", 32'h1004, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h3);
        step("pass", 32'h1004, 1'b1, 1'b0, 1'b0, 32'h3000, 32'hDEAD0000, 4'h2);
        load("reload", 32'h2000);

        step("st_wrap", 32'h1008, 1'b0, 1'b0, 1'b1, 32'h0102, 32'h55AA55AA, 4'h0);
        load("wrap_100", 32'h0100);
        load("wrap_2100", 32'h2100);
        load("wrap_2004", 32'h2004);

        step("rdwr", 32'h100C, 1'b1, 1'b1, 1'b1, 32'h2000, 32'h1, 4'h5);
        load("rdwr_after", 32'h2000);

        // Reset pulse in the middle of traffic, with a store pending.
        step("pre_rst", 32'h2000, 1'b1, 1'b1, 1'b1, 32'h0010, 32'h77, 4'h7);
        i_Sig_Memory_Write_Enable = 1'b1;
        i_Value_Rm = 32'hFFFF_FFFF;
        reset = 1'b0;
        #1;
        clear_model();
        chk_all("mid_rst");
        @(posedge clk);
        @(negedge clk);
        chk_all("mid_rst_hold");
        reset = 1'b1;
        load("post_rst_a", 32'h2000);
        load("post_rst_b", 32'h0010);
        load("post_rst_c", 32'h0100);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            step("rand", $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                 a, $urandom, 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
